// File: rtl/coprocessor_avalon_pkg.sv
// Shared types and constants for the coprocessor Avalon-MM master.
package coprocessor_avalon_pkg;

    localparam int          DATA_W = 32;
    localparam logic [3:0]  BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/coprocessor_avalon_master_if.sv
// Command/response and Avalon-MM signal bundle for the coprocessor master.
interface coprocessor_avalon_master_if #(parameter int ADDR_W = 32);
    import coprocessor_avalon_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    // master = the bridge itself; slave = coprocessor plus Avalon fabric around it
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

endinterface

// File: rtl/coprocessor_wait_timer.sv
// Counts stalled bus cycles; expired flags the last allowed waitrequest cycle.
module coprocessor_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count_q <= '0;
        else if (count_en && !expired)
            count_q <= count_q + 1'b1;
    end

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/coprocessor_avalon_master.sv
// Single-outstanding Avalon-MM master for coprocessor commands.
// Optional waitrequest timeout enabled by defining COPROC_MASTER_TIMEOUT_EN.
module coprocessor_avalon_master
    import coprocessor_avalon_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    coprocessor_avalon_master_if.master   bus
);

    state_t            state_q, state_d;
    logic              accept;
    logic              done;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef COPROC_MASTER_TIMEOUT_EN
    logic timer_expired;
    logic error_q;

    coprocessor_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .count_en ((state_q == ST_BUS) && bus.avm_waitrequest),
        .expired  (timer_expired)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // completion takes priority over a timeout landing in the same cycle
                if (!bus.avm_waitrequest) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef COPROC_MASTER_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef COPROC_MASTER_TIMEOUT_EN
            error_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                write_q <= bus.cmd_write;
                addr_q  <= {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= bus.cmd_wdata;
            end
            if (state_q == ST_BUS && state_d == ST_RESP) begin
                rdata_q <= (done && !write_q) ? bus.avm_readdata : '0;
`ifdef COPROC_MASTER_TIMEOUT_EN
                error_q <= !done;
`endif
            end
        end
    end

    assign bus.cmd_ready      = (state_q == ST_IDLE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.avm_read       = (state_q == ST_BUS) && !write_q;
    assign bus.avm_write      = (state_q == ST_BUS) && write_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = BE_ALL;
    assign bus.rsp_valid      = (state_q == ST_RESP);
    assign bus.rsp_rdata      = rdata_q;
`ifdef COPROC_MASTER_TIMEOUT_EN
    assign bus.rsp_error      = error_q;
`else
    assign bus.rsp_error      = 1'b0;
`endif

endmodule

// File: tb/tb_coprocessor_avalon_master.sv
// Directed bench for coprocessor_avalon_master (TIMEOUT=8; timeout cases follow COPROC_MASTER_TIMEOUT_EN).
module tb_coprocessor_avalon_master;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_rsp;

    coprocessor_avalon_master_if #(.ADDR_W(32)) bus_if ();

    coprocessor_avalon_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus_if.cmd_valid       = 1'b0;
        bus_if.cmd_write       = 1'b0;
        bus_if.cmd_addr        = '0;
        bus_if.cmd_wdata       = '0;
        bus_if.avm_readdata    = '0;
        bus_if.avm_waitrequest = 1'b0;
        tick();
        tick();

        check_val("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        check_val("rst_busy",      32'(bus_if.busy), 32'd0);
        check_val("rst_strobes",   32'({bus_if.avm_read, bus_if.avm_write}), 32'd0);
        check_val("rst_rsp",       32'({bus_if.rsp_valid, bus_if.rsp_error}), 32'd0);
        check_val("rst_rdata",     bus_if.rsp_rdata, 32'd0);
        check_val("rst_addr",      bus_if.avm_address, 32'd0);
        check_val("rst_wdata",     bus_if.avm_writedata, 32'd0);
        check_val("byteenable",    32'(bus_if.avm_byteenable), 32'hF);
        reset = 1'b0;
        tick();

        // write, no wait states
        present(1'b1, 32'h0000_1003, 32'hDEAD_BEEF);
        check_val("wr_accept_ready", 32'(bus_if.cmd_ready), 32'd1);
        tick();
        bus_if.cmd_valid = 1'b0;
        check_val("wr_strobe",   32'({bus_if.avm_read, bus_if.avm_write}), 32'b01);
        check_val("wr_addr",     bus_if.avm_address, 32'h0000_1000);
        check_val("wr_data",     bus_if.avm_writedata, 32'hDEAD_BEEF);
        check_val("wr_bus_ready", 32'(bus_if.cmd_ready), 32'd0);
        check_val("wr_busy",     32'(bus_if.busy), 32'd1);
        tick();
        check_val("wr_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_val("wr_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        check_val("wr_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        check_val("wr_resp_strobe", 32'({bus_if.avm_read, bus_if.avm_write}), 32'd0);
        check_val("wr_resp_ready", 32'(bus_if.cmd_ready), 32'd0);
        tick();
        check_val("wr_idle_rsp", 32'(bus_if.rsp_valid), 32'd0);
        check_val("wr_idle_ready", 32'(bus_if.cmd_ready), 32'd1);

        // read with three wait states
        present(1'b0, 32'h0000_0020, 32'h0);
        bus_if.avm_waitrequest = 1'b1;
        bus_if.avm_readdata    = 32'hBAD0_0000;
        tick();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("rd_wait_strobe", 32'({bus_if.avm_read, bus_if.avm_write}), 32'b10);
            check_val("rd_wait_addr",   bus_if.avm_address, 32'h0000_0020);
            check_val("rd_wait_rsp",    32'(bus_if.rsp_valid), 32'd0);
            tick();
        end
        bus_if.avm_waitrequest = 1'b0;
        bus_if.avm_readdata    = 32'h1234_5678;
        check_val("rd_last_strobe", 32'(bus_if.avm_read), 32'd1);
        tick();
        bus_if.avm_readdata = 32'h0;
        check_val("rd_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_val("rd_rsp_rdata", bus_if.rsp_rdata, 32'h1234_5678);
        tick();
        check_val("rd_rdata_hold", bus_if.rsp_rdata, 32'h1234_5678);
        check_val("rd_rsp_low",    32'(bus_if.rsp_valid), 32'd0);

        // cmd_valid held high: accept every third cycle
        present(1'b0, 32'h0000_0100, 32'h0);
        n_rsp = 0;
        for (int i = 0; i < 9; i++) begin
            bus_if.avm_readdata = 32'h1000 + 32'(i);
            check_val("b2b_ready", 32'(bus_if.cmd_ready), 32'((i % 3) == 0));
            if ((i % 3) == 2) begin
                check_val("b2b_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
                check_val("b2b_rdata", bus_if.rsp_rdata, 32'h1000 + 32'(i - 1));
            end
            if (bus_if.rsp_valid) n_rsp++;
            tick();
        end
        bus_if.cmd_valid = 1'b0;
        check_val("b2b_rsp_count", 32'(n_rsp), 32'd3);
        tick();
        tick();

        // waitrequest stuck high
        present(1'b0, 32'h0000_0040, 32'h0);
        bus_if.avm_waitrequest = 1'b1;
        bus_if.avm_readdata    = 32'h5555_AAAA;
        tick();
        bus_if.cmd_valid = 1'b0;
`ifdef COPROC_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check_val("to_strobe", 32'(bus_if.avm_read), 32'd1);
            check_val("to_rsp_low", 32'(bus_if.rsp_valid), 32'd0);
            tick();
        end
        check_val("to_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_val("to_rsp_error", 32'(bus_if.rsp_error), 32'd1);
        check_val("to_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        check_val("to_strobe_off", 32'(bus_if.avm_read), 32'd0);
        tick();
        check_val("to_error_hold", 32'(bus_if.rsp_error), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            check_val("nto_busy", 32'(bus_if.busy), 32'd1);
            check_val("nto_rsp_low", 32'(bus_if.rsp_valid), 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // waitrequest drops on the 8th bus cycle: completion wins
        present(1'b0, 32'h0000_0044, 32'h0);
        bus_if.avm_waitrequest = 1'b1;
        tick();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        bus_if.avm_waitrequest = 1'b0;
        bus_if.avm_readdata    = 32'hCAFE_F00D;
        check_val("late_strobe", 32'(bus_if.avm_read), 32'd1);
        tick();
        check_val("late_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_val("late_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        check_val("late_rdata", bus_if.rsp_rdata, 32'hCAFE_F00D);
        tick();

        // reset on the second bus cycle
        present(1'b1, 32'h0000_0080, 32'h0BAD_CAFE);
        bus_if.avm_waitrequest = 1'b1;
        tick();
        bus_if.cmd_valid = 1'b0;
        tick();
        check_val("rstbus_strobe_pre", 32'(bus_if.avm_write), 32'd1);
        reset = 1'b1;
        tick();
        check_val("rstbus_strobe", 32'({bus_if.avm_read, bus_if.avm_write}), 32'd0);
        check_val("rstbus_rsp", 32'(bus_if.rsp_valid), 32'd0);
        check_val("rstbus_rdata", bus_if.rsp_rdata, 32'd0);
        reset = 1'b0;
        bus_if.avm_waitrequest = 1'b0;
        tick();
        check_val("rstbus_ready", 32'(bus_if.cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_val("rstbus_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
